// File: rtl/present_seq_ctrl.sv
// rtl/present_seq_ctrl.sv - PRESENT cipher register-port sequencer with status polling
// Optional poll timeout (rsp_err) is built only when PRESENT_SEQ_TIMEOUT_EN is defined.
module present_seq_ctrl #(
   parameter int unsigned POLL_GAP   = 4,
   parameter int unsigned POLL_LIMIT = 1023
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [79:0] req_key,
   input  logic [63:0] req_text,
   input  logic        req_decrypt,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic        rsp_err,
   output logic        core_cs,
   output logic        core_we,
   output logic [3:0]  core_addr,
   output logic [31:0] core_wdat,
   input  logic [31:0] core_rdat,
   output logic        busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_WKEY, S_WTXT, S_START, S_POLL_RD, S_POLL_WAIT,
      S_POLL_GAP, S_RD_LO, S_RD_HI, S_RD_LAST, S_RESP
   } state_t;

   localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

   state_t      state, state_d;
   logic [7:0]  cnt, cnt_d;
   logic [79:0] key_q;
   logic [63:0] text_q;
   logic        dec_q;
   logic [63:0] data_q;
   logic        ready_q;
   logic        load, cap_lo, cap_hi;
   logic        timeout;

   // ready_q keeps req_ready low during reset and until the first edge after release
   assign req_ready = ready_q && (state == S_IDLE) && !rsp_valid;
   assign rsp_valid = (state == S_RESP);
   assign busy      = (state != S_IDLE);
   assign rsp_data  = data_q;

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      core_cs   = 1'b0;
      core_we   = 1'b0;
      core_addr = 4'd0;
      core_wdat = 32'd0;
      load      = 1'b0;
      cap_lo    = 1'b0;
      cap_hi    = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               load    = 1'b1;
               cnt_d   = 8'd0;
               state_d = S_WKEY;
            end
         end
         S_WKEY: begin
            core_cs   = 1'b1;
            core_we   = 1'b1;
            core_addr = {2'b00, cnt[1:0]};
            case (cnt[1:0])
               2'd0:    core_wdat = key_q[31:0];
               2'd1:    core_wdat = key_q[63:32];
               default: core_wdat = {16'd0, key_q[79:64]};
            endcase
            if (cnt[1:0] == 2'd2) begin
               cnt_d   = 8'd0;
               state_d = S_WTXT;
            end else begin
               cnt_d = cnt + 8'd1;
            end
         end
         S_WTXT: begin
            core_cs   = 1'b1;
            core_we   = 1'b1;
            core_addr = cnt[0] ? 4'd4 : 4'd3;
            core_wdat = cnt[0] ? text_q[63:32] : text_q[31:0];
            if (cnt[0]) begin
               cnt_d   = 8'd0;
               state_d = S_START;
            end else begin
               cnt_d = cnt + 8'd1;
            end
         end
         S_START: begin
            core_cs   = 1'b1;
            core_we   = 1'b1;
            core_addr = 4'd5;
            core_wdat = {30'd0, dec_q, 1'b1};
            state_d   = S_POLL_RD;
         end
         S_POLL_RD: begin
            core_cs   = 1'b1;
            core_addr = 4'd6;
            state_d   = S_POLL_WAIT;
         end
         S_POLL_WAIT: begin
            if (core_rdat[0]) begin
               state_d = S_RD_LO;
            end else if (timeout) begin
               state_d = S_RESP;
            end else begin
               cnt_d   = 8'd0;
               state_d = S_POLL_GAP;
            end
         end
         S_POLL_GAP: begin
            if (cnt == GAP_LAST) begin
               state_d = S_POLL_RD;
            end else begin
               cnt_d = cnt + 8'd1;
            end
         end
         S_RD_LO: begin
            core_cs   = 1'b1;
            core_addr = 4'd7;
            state_d   = S_RD_HI;
         end
         S_RD_HI: begin
            core_cs   = 1'b1;
            core_addr = 4'd8;
            cap_lo    = 1'b1;
            state_d   = S_RD_LAST;
         end
         S_RD_LAST: begin
            cap_hi  = 1'b1;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state   <= S_IDLE;
         cnt     <= 8'd0;
         key_q   <= 80'd0;
         text_q  <= 64'd0;
         dec_q   <= 1'b0;
         data_q  <= 64'd0;
         ready_q <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         ready_q <= 1'b1;
         if (load) begin
            key_q  <= req_key;
            text_q <= req_text;
            dec_q  <= req_decrypt;
            data_q <= 64'd0;
         end
         if (cap_lo) data_q[31:0]  <= core_rdat;
         if (cap_hi) data_q[63:32] <= core_rdat;
      end
   end

`ifdef PRESENT_SEQ_TIMEOUT_EN
   localparam logic [9:0] LIMIT = POLL_LIMIT[9:0];

   logic [9:0] poll_cnt;
   logic       err_q;

   assign timeout = (state == S_POLL_WAIT) && !core_rdat[0] && (poll_cnt >= LIMIT);
   assign rsp_err = err_q;

   // Counts issued status reads; saturates so a long stall can never wrap past the limit
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         poll_cnt <= 10'd0;
         err_q    <= 1'b0;
      end else begin
         if (load) begin
            poll_cnt <= 10'd0;
            err_q    <= 1'b0;
         end else if ((state == S_POLL_RD) && (poll_cnt != 10'h3FF)) begin
            poll_cnt <= poll_cnt + 10'd1;
         end
         if (timeout) err_q <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_present_seq_ctrl.sv
// tb/tb_present_seq_ctrl.sv - directed bench for present_seq_ctrl with a PRESENT-80 core model
module tb_present_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_decrypt;
   logic [79:0] req_key;
   logic [63:0] req_text;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [63:0] rsp_data;
   logic        core_cs, core_we, busy;
   logic [3:0]  core_addr;
   logic [31:0] core_wdat, core_rdat;

   int total = 0;
   int bad   = 0;

   present_seq_ctrl #(.POLL_GAP(4), .POLL_LIMIT(3)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
      .req_text(req_text), .req_decrypt(req_decrypt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .core_cs(core_cs), .core_we(core_we), .core_addr(core_addr),
      .core_wdat(core_wdat), .core_rdat(core_rdat), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] sb(input logic [3:0] x);
      case (x)
         4'h0: sb = 4'hC; 4'h1: sb = 4'h5; 4'h2: sb = 4'h6; 4'h3: sb = 4'hB;
         4'h4: sb = 4'h9; 4'h5: sb = 4'h0; 4'h6: sb = 4'hA; 4'h7: sb = 4'hD;
         4'h8: sb = 4'h3; 4'h9: sb = 4'hE; 4'hA: sb = 4'hF; 4'hB: sb = 4'h8;
         4'hC: sb = 4'h4; 4'hD: sb = 4'h7; 4'hE: sb = 4'h1; default: sb = 4'h2;
      endcase
   endfunction

   function automatic logic [3:0] isb(input logic [3:0] x);
      case (x)
         4'h0: isb = 4'h5; 4'h1: isb = 4'hE; 4'h2: isb = 4'hF; 4'h3: isb = 4'h8;
         4'h4: isb = 4'hC; 4'h5: isb = 4'h1; 4'h6: isb = 4'h2; 4'h7: isb = 4'hD;
         4'h8: isb = 4'hB; 4'h9: isb = 4'h4; 4'hA: isb = 4'h6; 4'hB: isb = 4'h3;
         4'hC: isb = 4'h0; 4'hD: isb = 4'h7; 4'hE: isb = 4'h9; default: isb = 4'hA;
      endcase
   endfunction

   function automatic logic [63:0] slayer(input logic [63:0] s, input logic inv);
      logic [63:0] o;
      o = '0;
      for (int j = 0; j < 16; j++) o[4*j +: 4] = inv ? isb(s[4*j +: 4]) : sb(s[4*j +: 4]);
      return o;
   endfunction

   function automatic logic [63:0] perm(input logic [63:0] s, input logic inv);
      logic [63:0] o;
      int p;
      o = '0;
      for (int i = 0; i < 64; i++) begin
         p = (i == 63) ? 63 : (i * 16) % 63;
         if (inv) o[i] = s[p];
         else     o[p] = s[i];
      end
      return o;
   endfunction

   function automatic logic [63:0] present(input logic [79:0] key, input logic [63:0] blk, input logic dec);
      logic [79:0] k;
      logic [63:0] rk [1:32];
      logic [63:0] s;
      k = key;
      for (int i = 1; i <= 32; i++) begin
         rk[i]     = k[79:16];
         k         = {k[18:0], k[79:19]};
         k[79:76]  = sb(k[79:76]);
         k[19:15]  = k[19:15] ^ 5'(i);
      end
      s = blk;
      if (!dec) begin
         for (int i = 1; i <= 31; i++) s = perm(slayer(s ^ rk[i], 1'b0), 1'b0);
         s = s ^ rk[32];
      end else begin
         s = s ^ rk[32];
         for (int i = 31; i >= 1; i--) s = slayer(perm(s, 1'b1), 1'b1) ^ rk[i];
      end
      return s;
   endfunction

   // Cipher core model: register file, result computed at start, done after done_at polls
   logic [31:0] regs [0:15];
   logic [63:0] res_q;
   logic [31:0] ctrl_last;
   int n_wr = 0, n_poll = 0, n_rd7 = 0, n_rd8 = 0, polls_since = 0;
   int done_at = 1;

   always @(posedge clk) begin
      if (core_cs && core_we) begin
         n_wr <= n_wr + 1;
         regs[core_addr] <= core_wdat;
         if (core_addr == 4'd5) begin
            ctrl_last   <= core_wdat;
            polls_since <= 0;
            res_q <= present({regs[2][15:0], regs[1], regs[0]}, {regs[4], regs[3]}, core_wdat[1]);
         end
         core_rdat <= 32'hDEAD_BEEF;
      end else if (core_cs) begin
         case (core_addr)
            4'd6: begin
               n_poll      <= n_poll + 1;
               polls_since <= polls_since + 1;
               core_rdat   <= {31'd0, (done_at != 0) && (polls_since + 1 >= done_at)};
            end
            4'd7: begin n_rd7 <= n_rd7 + 1; core_rdat <= res_q[31:0]; end
            4'd8: begin n_rd8 <= n_rd8 + 1; core_rdat <= res_q[63:32]; end
            default: core_rdat <= regs[core_addr];
         endcase
      end else begin
         core_rdat <= 32'hDEAD_BEEF;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where rsp_valid is seen (or budget runs out)
   task automatic do_req(input logic [79:0] k, input logic [63:0] t, input logic d,
                         input int budget, output int lat);
      int n;
      req_key = k; req_text = t; req_decrypt = d; req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      check("accept", {63'd0, n < 50}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < budget) begin @(negedge clk); lat++; end
   endtask

   task automatic rsp_hs();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_valid_cleared", {63'd0, rsp_valid}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, p0, r7, r8, w0;
      logic stable;
      rst_n = 1'b0; req_valid = 1'b0; req_key = '0; req_text = '0; req_decrypt = 1'b0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", {63'd0, req_ready}, 64'd0);
      check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst_busy",      {63'd0, busy}, 64'd0);
      check("rst_core",      {core_cs, core_we, core_addr, core_wdat}, 64'd0);
      check("rst_rsp_data",  rsp_data, 64'd0);
      check("rst_rsp_err",   {63'd0, rsp_err}, 64'd0);
      rst_n = 1'b1;
      #1 check("ready_before_edge", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      check("ready_after_edge", {63'd0, req_ready}, 64'd1);

      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_rsp_ready", {61'd0, rsp_valid, req_ready, busy}, 64'b010);
      rsp_ready = 1'b0;

      // encrypt zero key / zero text
      p0 = n_poll; r7 = n_rd7; r8 = n_rd8;
      do_req(80'd0, 64'd0, 1'b0, 200, lat);
      check("enc0_latency", 64'(lat), 64'd12);
      check("enc0_data", rsp_data, 64'h5579C1387B228445);
      check("enc0_err", {63'd0, rsp_err}, 64'd0);
      check("enc0_polls", 64'(n_poll - p0), 64'd1);
      check("enc0_rd78", {32'(n_rd7 - r7), 32'(n_rd8 - r8)}, {32'd1, 32'd1});
      check("enc0_ctrl", {32'd0, ctrl_last}, 64'h1);
      rsp_hs();

      do_req(80'd0, 64'h5579C1387B228445, 1'b1, 200, lat);
      check("dec_data", rsp_data, 64'd0);
      check("dec_ctrl", {32'd0, ctrl_last}, 64'h3);
      rsp_hs();

      do_req(80'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 200, lat);
      check("enc_k0_tf", rsp_data, 64'hA112FFC72F68417B);
      rsp_hs();

      do_req({80{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 200, lat);
      check("enc_kf_tf", rsp_data, 64'h3333DCD3213210D2);
      rsp_hs();

      // done on the third poll: 12 + 2*(POLL_GAP+2)
      done_at = 3;
      p0 = n_poll;
      do_req({80{1'b1}}, 64'd0, 1'b0, 200, lat);
      check("poll3_latency", 64'(lat), 64'd24);
      check("poll3_polls", 64'(n_poll - p0), 64'd3);
      check("poll3_data", rsp_data, 64'hE72C46C0F5945049);
      rsp_hs();
      done_at = 1;

      // hold response 10 cycles with a competing request pending
      do_req(80'd0, 64'd0, 1'b0, 200, lat);
      req_key = 80'd0; req_text = 64'hFFFF_FFFF_FFFF_FFFF; req_decrypt = 1'b0; req_valid = 1'b1;
      w0 = n_wr;
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!(rsp_valid === 1'b1 && rsp_data === 64'h5579C1387B228445 && req_ready === 1'b0))
            stable = 1'b0;
      end
      check("hold_stable", {63'd0, stable}, 64'd1);
      check("hold_no_writes", 64'(n_wr - w0), 64'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("hold_ready_after_hs", {62'd0, req_ready, rsp_valid}, 64'b10);
      @(posedge clk);
      @(negedge clk);
      req_text = 64'd0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      check("busy_ignore_latency", 64'(lat), 64'd12);
      check("busy_ignore_data", rsp_data, 64'hA112FFC72F68417B);
      req_valid = 1'b0;
      rsp_hs();

      // reset while writing the text block
      req_key = {80{1'b1}}; req_text = 64'h0123_4567_89AB_CDEF; req_decrypt = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("wtxt_issue", {27'd0, core_cs, core_we, core_addr, core_wdat}, {27'd0, 1'b1, 1'b1, 4'd3, 32'h89AB_CDEF});
      rst_n = 1'b0;
      #1;
      check("rst_mid_core", {core_cs, core_we, core_addr, core_wdat}, 64'd0);
      check("rst_mid_state", {61'd0, busy, req_ready, rsp_valid}, 64'd0);
      w0 = n_wr;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_no_writes", 64'(n_wr - w0), 64'd0);
      check("rst_mid_ready", {63'd0, req_ready}, 64'd1);
      do_req({80{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 200, lat);
      check("after_rst_latency", 64'(lat), 64'd12);
      check("after_rst_data", rsp_data, 64'h3333DCD3213210D2);
      rsp_hs();

      done_at = 0;
      p0 = n_poll; r7 = n_rd7; r8 = n_rd8;
`ifdef PRESENT_SEQ_TIMEOUT_EN
      do_req(80'd0, 64'd0, 1'b0, 200, lat);
      check("tmo_latency", 64'(lat), 64'd21);
      check("tmo_err", {63'd0, rsp_err}, 64'd1);
      check("tmo_data", rsp_data, 64'd0);
      check("tmo_polls", 64'(n_poll - p0), 64'd3);
      check("tmo_no_result_reads", {32'(n_rd7 - r7), 32'(n_rd8 - r8)}, 64'd0);
      rsp_hs();
`else
      do_req(80'd0, 64'd0, 1'b0, 100, lat);
      check("stuck_no_rsp", {63'd0, rsp_valid}, 64'd0);
      check("stuck_busy", {62'd0, busy, rsp_err}, 64'b10);
      check("stuck_polls_continue", {63'd0, (n_poll - p0) >= 10}, 64'd1);
      check("stuck_no_result_reads", {32'(n_rd7 - r7), 32'(n_rd8 - r8)}, 64'd0);
      rst_n = 1'b0;
      #1 check("stuck_rst_idle", {63'd0, busy}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
`endif
      done_at = 1;
      do_req(80'd0, 64'h5579C1387B228445, 1'b1, 200, lat);
      check("final_latency", 64'(lat), 64'd12);
      check("final_data", rsp_data, 64'd0);
      check("final_err", {63'd0, rsp_err}, 64'd0);
      rsp_hs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
